// File: rtl/ysyx_22050612_mem_arbiter.sv
// Shares the core's single memory port between instruction fetch (IFU) and
// load/store (LSU). One transaction is in flight at a time. Ties go round-robin.
// A watchdog turns a missing memory response into an error response, so a
// dead memory cannot stall the core forever.
module ysyx_22050612_mem_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   // instruction fetch side
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_resp_valid,
   output logic                ifu_resp_err,
   output logic [DATA_W-1:0]   ifu_rdata,
   // load/store side
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_resp_valid,
   output logic                lsu_resp_err,
   output logic [DATA_W-1:0]   lsu_rdata,
   // memory side
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   // Wide enough to hold TIMEOUT-1; cleared on WAIT entry so it never wraps.
   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic G_IFU = 1'b0;
   localparam logic G_LSU = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t           state_reg;
   logic             last_grant_reg;
   logic             grantee_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic pick_lsu;
   logic in_idle;
   logic in_wait;
   logic resp_hit;
   logic timeout_hit;
   logic done;

   // Arbitration and response decode; all handshakes are muted while reset is held
   always_comb begin
      // LSU wins when it is alone, or on a tie when IFU had the last grant
      pick_lsu    = lsu_req_valid && (!ifu_req_valid || last_grant_reg == G_IFU);
      in_idle     = (state_reg == IDLE) && !rst;
      in_wait     = (state_reg == WAIT) && !rst;
      resp_hit    = in_wait && mem_resp_valid;
      // a real response in the last watchdog cycle takes priority over the error
      timeout_hit = in_wait && !mem_resp_valid && (cnt_reg == CNT_LAST);
      done        = resp_hit || timeout_hit;

      ifu_req_ready  = in_idle && ifu_req_valid && !pick_lsu;
      lsu_req_ready  = in_idle && pick_lsu;

      ifu_resp_valid = done && (grantee_reg == G_IFU);
      ifu_resp_err   = timeout_hit && (grantee_reg == G_IFU);
      ifu_rdata      = (resp_hit && grantee_reg == G_IFU) ? mem_rdata : '0;

      lsu_resp_valid = done && (grantee_reg == G_LSU);
      lsu_resp_err   = timeout_hit && (grantee_reg == G_LSU);
      lsu_rdata      = (resp_hit && grantee_reg == G_LSU) ? mem_rdata : '0;
   end

   // Transaction FSM: latch the winner's request, present it, then wait for the answer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= G_IFU;
         grantee_reg    <= G_IFU;
         cnt_reg        <= '0;
         mem_req_valid  <= 1'b0;
         mem_addr       <= '0;
         mem_wen        <= 1'b0;
         mem_wdata      <= '0;
         mem_wmask      <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (ifu_req_ready || lsu_req_ready) begin
                  grantee_reg    <= pick_lsu;
                  last_grant_reg <= pick_lsu;
                  mem_req_valid  <= 1'b1;
                  state_reg      <= REQ;
                  if (pick_lsu) begin
                     mem_addr  <= lsu_addr;
                     mem_wen   <= lsu_wen;
                     mem_wdata <= lsu_wdata;
                     mem_wmask <= lsu_wmask;
                  end else begin
                     // instruction fetch is always a plain read
                     mem_addr  <= ifu_addr;
                     mem_wen   <= 1'b0;
                     mem_wdata <= '0;
                     mem_wmask <= '0;
                  end
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  cnt_reg       <= '0;
                  state_reg     <= WAIT;
               end
            end
            WAIT: begin
               if (done) begin
                  state_reg <= IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Scoreboard bench for the IFU/LSU memory arbiter: directed scenarios followed
// by randomized traffic against a reactive memory model.
module tb_ysyx_22050612_mem_arbiter;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int TO = 6;

   logic clk = 1'b0;
   logic rst;
   logic ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
   logic [AW-1:0] ifu_addr;
   logic [DW-1:0] ifu_rdata;
   logic lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
   logic [AW-1:0] lsu_addr;
   logic [DW-1:0] lsu_wdata, lsu_rdata;
   logic [DW/8-1:0] lsu_wmask;
   logic mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [DW/8-1:0] mem_wmask;

   ysyx_22050612_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_err(ifu_resp_err), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_err(lsu_resp_err), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0]   addr;
      logic            wen;
      logic [DW-1:0]   wdata;
      logic [DW/8-1:0] wmask;
   } mreq_t;
   typedef struct {
      bit            who;   // 0 = IFU, 1 = LSU
      bit            err;
      logic [DW-1:0] data;
   } resp_t;

   mreq_t mreq_q[$];     // expected memory requests, in grant order
   resp_t exp_q[$];      // expected responses, pushed by the memory model
   bit    grant_q[$];    // grantee per accepted request, consumed by the memory model
   bit    grant_log[$];
   int    acc_log[$];

   int checks = 0;
   int errors = 0;

   // reference model state
   bit m_busy = 0;
   bit m_last = 0;
   int last_acc_cyc = 0, last_resp_cyc = 0, resp_count = 0, req_valid_cycles = 0;
   bit last_resp_err = 0;

   // memory model configuration (-1 = random)
   int cfg_rd = 0, cfg_ra = 0;
   bit cfg_hold = 0, cfg_noise = 0, cfg_data_fixed = 0, mem_flush = 0;
   logic [DW-1:0] cfg_data = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ifu_ready"}, 64'(ifu_req_ready), 64'(0));
      chk({tag, "_lsu_ready"}, 64'(lsu_req_ready), 64'(0));
      chk({tag, "_ifu_resp"}, 64'({ifu_resp_valid, ifu_resp_err}), 64'(0));
      chk({tag, "_lsu_resp"}, 64'({lsu_resp_valid, lsu_resp_err}), 64'(0));
      chk({tag, "_ifu_rdata"}, ifu_rdata, 64'(0));
      chk({tag, "_lsu_rdata"}, lsu_rdata, 64'(0));
      chk({tag, "_mem_valid_wen"}, 64'({mem_req_valid, mem_wen}), 64'(0));
      chk({tag, "_mem_addr"}, mem_addr, 64'(0));
      chk({tag, "_mem_wdata"}, mem_wdata, 64'(0));
      chk({tag, "_mem_wmask"}, 64'(mem_wmask), 64'(0));
   endtask

   // Monitor/scoreboard: predicts grants from the arbitration rules and checks every output
   initial begin
      bit winner, e_ifu, e_lsu, have_cur;
      mreq_t cur, r;
      resp_t e;
      have_cur = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_busy = 0; m_last = 0; have_cur = 0;
            mreq_q.delete(); exp_q.delete(); grant_q.delete();
            chk("rst_quiet", 64'({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid}), 64'(0));
         end else begin
            // tie goes to the side opposite the last grant; otherwise the lone requester
            if (ifu_req_valid && lsu_req_valid) winner = !m_last;
            else winner = lsu_req_valid;
            e_lsu = !m_busy && lsu_req_valid && winner;
            e_ifu = !m_busy && ifu_req_valid && !winner;
            chk("ifu_ready", 64'(ifu_req_ready), 64'(e_ifu));
            chk("lsu_ready", 64'(lsu_req_ready), 64'(e_lsu));
            if (e_ifu || e_lsu) begin
               if (e_lsu) begin
                  r.addr = lsu_addr; r.wen = lsu_wen; r.wdata = lsu_wdata; r.wmask = lsu_wmask;
               end else begin
                  r.addr = ifu_addr; r.wen = 1'b0; r.wdata = '0; r.wmask = '0;
               end
               mreq_q.push_back(r);
               grant_q.push_back(e_lsu);
               grant_log.push_back(e_lsu);
               acc_log.push_back(cyc);
               m_busy = 1; m_last = e_lsu; last_acc_cyc = cyc;
            end
            // memory request side: must hold until accepted, fields stable
            if (have_cur) chk("mem_req_hold", 64'(mem_req_valid), 64'(1));
            if (mem_req_valid) begin
               req_valid_cycles++;
               if (!have_cur) begin
                  checks++;
                  if (mreq_q.size() == 0) begin
                     errors++;
                     $display("FAIL spurious_mem_req: got valid=1 expected valid=0 (cycle %0d)", cyc);
                  end else begin
                     cur = mreq_q.pop_front();
                     have_cur = 1;
                  end
               end
               if (have_cur) begin
                  chk("mem_addr", mem_addr, cur.addr);
                  chk("mem_wen", 64'(mem_wen), 64'(cur.wen));
                  chk("mem_wdata", mem_wdata, cur.wdata);
                  chk("mem_wmask", 64'(mem_wmask), 64'(cur.wmask));
                  if (mem_req_ready) have_cur = 0;
               end
            end
            // response side
            if (ifu_resp_valid || lsu_resp_valid) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_resp: got ifu=%0d lsu=%0d expected none (cycle %0d)",
                           ifu_resp_valid, lsu_resp_valid, cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("resp_who", 64'({ifu_resp_valid, lsu_resp_valid}), e.who ? 64'(1) : 64'(2));
                  chk("resp_err", 64'(e.who ? lsu_resp_err : ifu_resp_err), 64'(e.err));
                  chk("resp_data", e.who ? lsu_rdata : ifu_rdata, e.data);
                  $display("resp %s err=%0d data=%h cycle=%0d", e.who ? "LSU" : "IFU", e.err, e.data, cyc);
               end
               last_resp_err = ifu_resp_valid ? ifu_resp_err : lsu_resp_err;
               last_resp_cyc = cyc;
               resp_count++;
               m_busy = 0;
            end
            if (!ifu_resp_valid) chk("ifu_quiet", ifu_rdata | 64'(ifu_resp_err), 64'(0));
            if (!lsu_resp_valid) chk("lsu_quiet", lsu_rdata | 64'(lsu_resp_err), 64'(0));
         end
      end
   end

   // Reactive memory: random/forced ready delay, response delay counted in WAIT cycles
   initial begin
      int phase, rd, ra, k;
      bit who;
      logic [DW-1:0] d;
      resp_t r;
      phase = 0; rd = 0; ra = 0; k = 0; who = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = {$urandom, $urandom};
         if (mem_flush) begin
            mem_flush = 0; phase = 0;
            continue;
         end
         if (phase == 0 && mem_req_valid) begin
            rd = (cfg_rd >= 0) ? cfg_rd : int'($urandom_range(0, 3));
            phase = 1;
         end
         if (phase == 1) begin
            if (rd == 0) begin
               mem_req_ready = 1; phase = 2; k = -1;
               ra = (cfg_ra >= 0) ? cfg_ra : int'($urandom_range(0, TO + 1));
               who = (grant_q.size() > 0) ? grant_q.pop_front() : 1'b0;
            end else begin
               rd--;
            end
         end else if (phase == 2) begin
            k++;
            if (!cfg_hold && k == ra) begin
               d = cfg_data_fixed ? cfg_data : {$urandom, $urandom};
               mem_resp_valid = 1; mem_rdata = d;
               if (ra <= TO - 1) begin
                  r.who = who; r.err = 0; r.data = d;
                  exp_q.push_back(r);
               end
               phase = 0;
            end else if (!cfg_hold && ra > TO - 1 && k == TO - 1) begin
               r.who = who; r.err = 1; r.data = '0;
               exp_q.push_back(r);
            end
         end
         if (cfg_noise && phase != 2 && !mem_resp_valid && $urandom_range(0, 3) == 0)
            mem_resp_valid = 1;
      end
   end

   task automatic wait_accept(input bit lsu);
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (lsu ? lsu_req_ready : ifu_req_ready) return;
      end
      checks++; errors++;
      $display("FAIL accept_timeout: got no ready for %s expected ready within 400 cycles", lsu ? "LSU" : "IFU");
   endtask

   // called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic ifu_issue(input logic [AW-1:0] a);
      ifu_addr = a; ifu_req_valid = 1;
      wait_accept(0);
      @(posedge clk); #1;
      ifu_req_valid = 0;
   endtask

   task automatic lsu_issue(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                            input logic [DW/8-1:0] wm);
      lsu_addr = a; lsu_wen = w; lsu_wdata = wd; lsu_wmask = wm; lsu_req_valid = 1;
      wait_accept(1);
      @(posedge clk); #1;
      lsu_req_valid = 0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int n = 0; n < 500 && !ok; n++) begin
         @(negedge clk);
         if (!m_busy && exp_q.size() == 0 && mreq_q.size() == 0) ok = 1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL idle_timeout: got busy=%0d pending=%0d expected idle", m_busy, exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int base, abase, rc;
      rst = 1;
      ifu_req_valid = 0; ifu_addr = '0;
      lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); check_zero("in_reset");
      @(posedge clk); #1; rst = 0;
      @(negedge clk); check_zero("after_reset");
      @(posedge clk); #1;

      // IFU-only read, zero-wait memory
      cfg_rd = 0; cfg_ra = 0; cfg_data = 64'h13; cfg_data_fixed = 1;
      ifu_issue(64'h8000_0000);
      wait_idle();
      chk("t1_latency", 64'(last_resp_cyc - last_acc_cyc), 64'(2));
      chk("t1_err", 64'(last_resp_err), 64'(0));
      cfg_data_fixed = 0;

      // both requesting continuously: LSU, IFU, LSU, IFU
      base = grant_log.size(); abase = acc_log.size();
      fork
         begin for (int i = 0; i < 4; i++) ifu_issue(64'h8000_0100 + 64'(i * 4)); end
         begin for (int i = 0; i < 4; i++) lsu_issue(64'h8000_2000 + 64'(i * 8), i[0], {$urandom, $urandom}, 8'hFF); end
      join
      wait_idle();
      chk("t2_count", 64'(grant_log.size() - base), 64'(8));
      if (grant_log.size() >= base + 4)
         for (int i = 0; i < 4; i++) chk("t2_order", 64'(grant_log[base + i]), 64'(i % 2 == 0));
      if (acc_log.size() >= abase + 4)
         for (int i = 0; i < 3; i++) chk("t2_spacing", 64'(acc_log[abase + i + 1] - acc_log[abase + i]), 64'(3));

      // LSU write with memory stalling the request for 5 cycles
      cfg_rd = 5; cfg_ra = 0; req_valid_cycles = 0;
      lsu_issue(64'h8000_1000, 1, 64'hDEAD_BEEF, 8'h0F);
      wait_idle();
      chk("t3_valid_cycles", 64'(req_valid_cycles), 64'(6));
      chk("t3_latency", 64'(last_resp_cyc - last_acc_cyc), 64'(7));

      // timeout with a late response afterwards
      cfg_rd = 0; cfg_ra = TO + 1;
      ifu_issue(64'h8000_0040);
      wait_idle();
      chk("t4_latency", 64'(last_resp_cyc - last_acc_cyc), 64'(TO + 1));
      chk("t4_err", 64'(last_resp_err), 64'(1));
      rc = resp_count;
      repeat (4) @(posedge clk); #1;
      chk("t4_no_late_pulse", 64'(resp_count - rc), 64'(0));

      // reset while waiting for the memory
      cfg_rd = 0; cfg_hold = 1; rc = resp_count;
      lsu_issue(64'h8000_3000, 0, '0, '0);
      @(posedge clk); #1;
      rst = 1; mem_flush = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk); check_zero("t5_after_rst");
      cfg_hold = 0; cfg_ra = 0;
      repeat (TO + 2) @(posedge clk); #1;
      chk("t5_no_pulse", 64'(resp_count - rc), 64'(0));
      base = grant_log.size();
      fork
         ifu_issue(64'h8000_0080);
         lsu_issue(64'h8000_4000, 0, '0, '0);
      join
      wait_idle();
      chk("t5_count", 64'(grant_log.size() - base), 64'(2));
      if (grant_log.size() >= base + 2) begin
         chk("t5_tie_first", 64'(grant_log[base]), 64'(1));
         chk("t5_tie_second", 64'(grant_log[base + 1]), 64'(0));
      end

      // response arriving in the last watchdog cycle wins over the error
      cfg_rd = 0; cfg_ra = TO - 1;
      ifu_issue(64'h8000_00C0);
      wait_idle();
      chk("t6_latency", 64'(last_resp_cyc - last_acc_cyc), 64'(TO + 1));
      chk("t6_err", 64'(last_resp_err), 64'(0));

      // randomized traffic
      cfg_rd = -1; cfg_ra = -1; cfg_noise = 1;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               ifu_issue({32'h0, $urandom});
            end
         end
         begin
            for (int i = 0; i < 60; i++) begin
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               lsu_issue({$urandom, $urandom}, 1'($urandom), {$urandom, $urandom}, 8'($urandom));
            end
         end
      join
      wait_idle();
      cfg_noise = 0;
      repeat (TO + 3) @(posedge clk); #1;
      chk("final_queues_empty", 64'(exp_q.size() + mreq_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_22050612_mem_arbiter.md
Name: ysyx_22050612_mem_arbiter

Overview:
Two-requester arbiter that shares the core's single memory port between instruction fetch (IFU) and load/store (LSU).
- Allows one outstanding transaction at a time.
- Round-robin on contention.
- Request/response handshake on both sides.
- Response-timeout watchdog, so a dead memory cannot hang the core.
- Sits between IFU/LSU and the memory bus bridge, alongside the execute datapath.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
TIMEOUT, 255, max cycles in WAIT before error response (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  IFU read address
ifu_resp_valid  out  1  IFU response pulse
ifu_resp_err  out  1  IFU response is a timeout error
ifu_rdata  out  DATA_W  IFU read data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_W  LSU address
lsu_wen  in  1  1=write, 0=read
lsu_wdata  in  DATA_W  write data
lsu_wmask  in  DATA_W/8  byte write mask
lsu_resp_valid  out  1  LSU response pulse
lsu_resp_err  out  1  LSU response is a timeout error
lsu_rdata  out  DATA_W  LSU read data
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  latched address
mem_wen  out  1  latched write enable (0 for IFU)
mem_wdata  out  DATA_W  latched write data (0 for IFU)
mem_wmask  out  DATA_W/8  latched mask (0 for IFU)
mem_resp_valid  in  1  memory response
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset:
  - state=IDLE, last_grant=IFU, cnt=0.
  - Latched request registers cleared.
  - All outputs 0.
  - Reset mid-transaction abandons it; no response is issued to the requester.
- States:
  - IDLE -> REQ on accept.
  - REQ -> WAIT on mem_req_ready.
  - WAIT -> IDLE on mem_resp_valid or timeout.
- IDLE arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester opposite last_grant wins. After reset LSU wins the first tie.
  - The winner's *_req_ready is asserted combinationally in IDLE only; the loser's ready stays 0.
  - On accept: latch addr/wen/wdata/wmask (IFU: wen=0, wdata=0, wmask=0), record grantee, update last_grant, go REQ.
- REQ:
  - mem_req_valid=1 and mem_* driven from latches, stable until mem_req_ready.
  - On mem_req_ready: go WAIT, cnt=0.
  - mem_resp_valid is ignored in REQ.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid: grantee *_resp_valid=1 and *_rdata=mem_rdata combinationally that cycle, resp_err=0, go IDLE.
  - Otherwise cnt increments. When cnt==TIMEOUT-1 with no response: grantee resp_valid=1, resp_err=1, rdata=0, go IDLE.
  - Response and timeout in the same cycle: the response wins, err=0.
- Non-grantee resp_valid/resp_err are always 0. rdata outputs are 0 when their resp_valid=0.
- mem_resp_valid while IDLE (late response after timeout) is ignored.
- No new request is accepted in the cycle a response is delivered. Earliest next accept is the following IDLE cycle.
- Minimum latency, zero-wait memory: accept cycle 0, mem_req_valid cycle 1, response cycle 2, next accept cycle 3.
- cnt is log2(TIMEOUT)+1 bits wide and never wraps: it is cleared on WAIT entry.

Test Plan:
- Reset then IFU-only read addr 0x80000000; memory ready immediately, resp 1 cycle later with data 0x00000013 -> ifu_req_ready at cycle 0, mem_addr=0x80000000, mem_wen=0, ifu_resp_valid one cycle with data 0x13, lsu outputs stay 0.
- Both valid continuously after reset, zero-wait memory -> grants LSU, IFU, LSU, IFU in order; each mem request carries the correct latched fields.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F; mem_req_ready held low 5 cycles -> mem_req_valid and all mem_* fields stable for 6 cycles; lsu_resp_valid after the response.
- TIMEOUT=4, memory never responds -> resp_valid=1, resp_err=1, rdata=0 exactly 4 cycles after WAIT entry; a mem_resp_valid arriving later is ignored and causes no pulse.
- rst asserted while in WAIT -> next cycle state IDLE, all outputs 0, no response pulse; a following IFU request is accepted normally with IFU/LSU tie priority reset.
- Response and timeout in the same cycle (TIMEOUT=3, mem_resp_valid at cnt==2) -> resp_err=0 and rdata=mem_rdata.
